vec_cache_rdb_data_arb: RTL and testbench
=========================================

# vec_cache_rdb_data_arb

Parametrised, registered arbiter between the per-channel data-out ports of one direction (east/west/north/south) and the read data buffer (RDB) and, optionally, the eviction data buffer (EVDB). Each hash group of `CH_PER_GRP` channels is funnelled to one RDB lane and one EVDB lane. Channels that collide in the same cycle are held in a per-group skid FIFO and replayed, not lost. The block is instantiated once per direction, between the channel datapath and the RDB/EVDB write ports.

## Interface
- `NUM_GRP`, 4: number of hash groups, which is also the number of output lanes.
- `CH_PER_GRP`, 2: channels per group. Channel `c` of group `g` is input index `g*CH_PER_GRP+c`.
- `SKID_DEPTH`, 2: pending-FIFO entries per group per class. Must be ≥1.
- `SPLIT_EVICT`, 0: when 1, beats are split by opcode into RDB and EVDB streams.
- `clk`  in  1  clock.
- `rst`  in  1  synchronous, active-high reset.
- `in_vld`  in  NUM_GRP*CH_PER_GRP  per-channel beat valid.
- `in_pld`  in  group_data_pld_t [NUM_GRP*CH_PER_GRP]  per-channel beat.
- `rdb_vld`  out  NUM_GRP  RDB lane valid.
- `rdb_pld`  out  group_data_pld_t [NUM_GRP]  RDB lane beat.
- `evdb_vld`  out  NUM_GRP  EVDB lane valid. Tied to 0 when SPLIT_EVICT=0.
- `evdb_pld`  out  group_data_pld_t [NUM_GRP]  EVDB lane beat.
- `ovf_err`  out  NUM_GRP  sticky per-group overflow flag.
- `conflict_cnt`  out  16  collision count, present only under the configuration macro.

## Operation
- **Classification.**
  - SPLIT_EVICT=1: `cmd_pld.opcode==OPC_READ` (2'd1) goes to the RDB class. `OPC_EVICT` (2'd2) goes to the EVDB class. Any other opcode is dropped silently.
  - SPLIT_EVICT=0: every valid beat goes to the RDB class.
- **Per group, per class, each cycle:**
  - Winner: if the FIFO is non-empty, the FIFO head wins. Otherwise the first valid channel of that class wins, scanning from `rr_ptr` upward with wrap.
  - All other valid beats of that class are pushed into the FIFO that cycle, in the same scan order starting at `rr_ptr`. This is a multi-push of up to CH_PER_GRP beats per cycle.
  - FIFO free space is counted after the pop. Beats beyond the free space are dropped, and `ovf_err[g]` is set.
  - When a channel (not the FIFO) wins, `rr_ptr` advances to winner+1 mod CH_PER_GRP. Otherwise `rr_ptr` holds.
  - The RDB and EVDB classes arbitrate independently. One group can emit one RDB beat and one EVDB beat in the same cycle.
- There is no backpressure in either direction. The RDB and EVDB accept one beat per lane per cycle.
- **Ordering.** Beats from the same channel leave in arrival order. A new beat never overtakes a FIFO-resident beat of the same group and class.

## Timing
- All outputs are registered.
- Latency is 1 cycle for an uncontended beat. A beat pushed into the FIFO at depth position k leaves k+1 cycles after arrival.
- Reset values: `rdb_vld`, `evdb_vld`, `ovf_err` = 0. `rdb_pld`, `evdb_pld` = '0. `rr_ptr` = 0. FIFOs empty. `conflict_cnt` = 0.
- Reset asserted mid-operation flushes all FIFOs. Beats presented during reset are discarded. Valid outputs are 0 in the cycle after reset is sampled high.
- `ovf_err` is cleared only by `rst`.
- FIFO count width is $clog2(SKID_DEPTH+1). Pointers wrap modulo SKID_DEPTH.
- In the same cycle as a pop, the FIFO can take pushes up to SKID_DEPTH − count + 1.

## Configuration
- Macro: `VEC_CACHE_RDB_ARB_CONFLICT_CNT_EN`.
  - Defined: `conflict_cnt` increments by 1 in every cycle in which any group and class has more than one candidate (FIFO head plus valid channels). The counter saturates at 16'hFFFF.
  - Undefined: the counter logic is absent and the `conflict_cnt` port is not declared.

## Structure
- `vector_cache_pkg` holds `group_data_pld_t`, `OPC_READ` and `OPC_EVICT`.
- One sub-module, `vec_cache_rdb_grp_arb`: one group, one class. It contains the skid FIFO, the round-robin pointer and the output register.
- The top level generates NUM_GRP instances of `vec_cache_rdb_grp_arb` for the RDB class, plus NUM_GRP more for the EVDB class when SPLIT_EVICT=1, and handles opcode classification.

## Test plan
Defaults apply unless stated (NUM_GRP=4, CH_PER_GRP=2, SKID_DEPTH=2).
- **Single beat:** `in_vld=8'h04` with payload A, one cycle → `rdb_vld=4'b0010`, `rdb_pld[1]=A` one cycle later, then idle.
- **Collision, rr_ptr=0:** `in_vld[0]` and `in_vld[1]` both valid (A, B) for one cycle → `rdb_pld[0]` = A at t+1 and B at t+2. `ovf_err=0`.
- **Overflow:** group 0 channels both valid for 3 consecutive cycles → FIFO fills and one beat drops. `ovf_err[0]=1` and stays 1 until `rst`. Exactly 5 beats emerge, in order.
- **SPLIT_EVICT=1:** channel 0 opcode 1 and channel 1 opcode 2 in the same cycle → `rdb_vld[0]=1` and `evdb_vld[0]=1` in the same next cycle, no FIFO use. Opcode 0 → no output.
- **Reset mid-drain:** FIFO holding 2 beats, `rst` pulsed for 1 cycle → no stale beat appears afterwards. All outputs are 0.
- **Counter, macro defined:** 10 collision cycles → `conflict_cnt=10`.

Source files
------------

// File: rtl/vector_cache_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// vector_cache_pkg : shared beat payload type and opcode encodings
// Rev 1.0
// ---------------------------------------------------------------------------
package vector_cache_pkg;

  localparam logic [1:0] OPC_READ  = 2'd1;
  localparam logic [1:0] OPC_EVICT = 2'd2;

  typedef struct packed {
    logic [1:0] opcode;
    logic [5:0] txn_id;
  } cmd_pld_t;

  typedef struct packed {
    cmd_pld_t    cmd_pld;
    logic [15:0] data;
  } group_data_pld_t;

endpackage
`default_nettype wire

// File: rtl/vec_cache_rdb_grp_arb.sv
`default_nettype none
// ---------------------------------------------------------------------------
// vec_cache_rdb_grp_arb : one group / one class arbiter with multi-push skid
// FIFO, round-robin pointer and registered output. Optional conflict flag
// under VEC_CACHE_RDB_ARB_CONFLICT_CNT_EN.  Rev 1.0
// ---------------------------------------------------------------------------
module vec_cache_rdb_grp_arb
  import vector_cache_pkg::*;
#(
  parameter int CH_PER_GRP = 2,
  parameter int SKID_DEPTH = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [CH_PER_GRP-1:0] i_vld,
  input  group_data_pld_t       i_pld [CH_PER_GRP],
  output logic                  o_vld,
  output group_data_pld_t       o_pld,
  output logic                  o_ovf
`ifdef VEC_CACHE_RDB_ARB_CONFLICT_CNT_EN
  , output logic                o_conflict
`endif
);

  localparam int CW = $clog2(SKID_DEPTH + 1);
  localparam int PW = (SKID_DEPTH > 1) ? $clog2(SKID_DEPTH) : 1;
  localparam int RW = (CH_PER_GRP > 1) ? $clog2(CH_PER_GRP) : 1;

  logic [CW-1:0]   r_cnt;
  logic [PW-1:0]   r_rd_ptr;
  logic [PW-1:0]   r_wr_ptr;
  logic [RW-1:0]   r_rr;
  group_data_pld_t r_mem [SKID_DEPTH];
  logic            r_vld;
  group_data_pld_t r_pld;
  logic            r_ovf;

  logic                  w_fifo_ne;
  logic                  w_win_vld;
  group_data_pld_t       w_win_pld;
  logic                  w_drop;
  logic [RW-1:0]         w_rr_nxt;
  logic [CW-1:0]         w_cnt_nxt;
  logic [PW-1:0]         w_rd_ptr_nxt;
  logic [PW-1:0]         w_wr_ptr_nxt;
  logic [SKID_DEPTH-1:0] w_wr_en;
  group_data_pld_t       w_wr_pld [SKID_DEPTH];

  // FIFO head has priority; channel losers are pushed in scan order into the
  // space left after this cycle's pop.
  always_comb begin
    int n_push;
    int free;
    int idx;
    int slot;
    logic [RW-1:0] sel;
    logic [PW-1:0] wsel;
    n_push    = 0;
    idx       = 0;
    slot      = 0;
    sel       = '0;
    wsel      = '0;
    w_drop    = 1'b0;
    w_rr_nxt  = r_rr;
    w_wr_en   = '0;
    for (int s = 0; s < SKID_DEPTH; s++) w_wr_pld[s] = '0;
    w_fifo_ne = (r_cnt != '0);
    w_win_vld = w_fifo_ne;
    w_win_pld = r_mem[r_rd_ptr];
    free      = SKID_DEPTH - int'(r_cnt) + int'(w_fifo_ne);
    for (int i = 0; i < CH_PER_GRP; i++) begin
      idx = int'(r_rr) + i;
      if (idx >= CH_PER_GRP) idx = idx - CH_PER_GRP;
      sel = RW'(idx);
      if (i_vld[sel]) begin
        if (!w_win_vld) begin
          w_win_vld = 1'b1;
          w_win_pld = i_pld[sel];
          w_rr_nxt  = (idx + 1 == CH_PER_GRP) ? '0 : RW'(idx + 1);
        end else if (n_push < free) begin
          slot = int'(r_wr_ptr) + n_push;
          if (slot >= SKID_DEPTH) slot = slot - SKID_DEPTH;
          wsel = PW'(slot);
          w_wr_en[wsel]  = 1'b1;
          w_wr_pld[wsel] = i_pld[sel];
          n_push = n_push + 1;
        end else begin
          w_drop = 1'b1;
        end
      end
    end
    slot = int'(r_wr_ptr) + n_push;
    if (slot >= SKID_DEPTH) slot = slot - SKID_DEPTH;
    w_wr_ptr_nxt = PW'(slot);
    w_rd_ptr_nxt = r_rd_ptr;
    if (w_fifo_ne)
      w_rd_ptr_nxt = (int'(r_rd_ptr) + 1 == SKID_DEPTH) ? '0 : PW'(int'(r_rd_ptr) + 1);
    w_cnt_nxt = CW'(int'(r_cnt) - int'(w_fifo_ne) + n_push);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt    <= '0;
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_rr     <= '0;
      r_vld    <= 1'b0;
      r_pld    <= '0;
      r_ovf    <= 1'b0;
    end else begin
      r_cnt    <= w_cnt_nxt;
      r_rd_ptr <= w_rd_ptr_nxt;
      r_wr_ptr <= w_wr_ptr_nxt;
      r_rr     <= w_rr_nxt;
      r_vld    <= w_win_vld;
      if (w_win_vld) r_pld <= w_win_pld;
      if (w_drop) r_ovf <= 1'b1;
    end
  end

  // Storage needs no reset: the count is what defines occupancy.
  always_ff @(posedge clk) begin
    for (int s = 0; s < SKID_DEPTH; s++) begin
      if (w_wr_en[s]) r_mem[s] <= w_wr_pld[s];
    end
  end

  assign o_vld = r_vld;
  assign o_pld = r_pld;
  assign o_ovf = r_ovf;

`ifdef VEC_CACHE_RDB_ARB_CONFLICT_CNT_EN
  assign o_conflict = (int'(w_fifo_ne) + $countones(i_vld)) > 1;
`endif

endmodule
`default_nettype wire

// File: rtl/vec_cache_rdb_data_arb.sv
`default_nettype none
// ---------------------------------------------------------------------------
// vec_cache_rdb_data_arb : per-direction channel -> RDB/EVDB lane arbiter.
// Optional collision counter: VEC_CACHE_RDB_ARB_CONFLICT_CNT_EN.  Rev 1.0
// ---------------------------------------------------------------------------
module vec_cache_rdb_data_arb
  import vector_cache_pkg::*;
#(
  parameter int NUM_GRP     = 4,
  parameter int CH_PER_GRP  = 2,
  parameter int SKID_DEPTH  = 2,
  parameter int SPLIT_EVICT = 0
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_GRP*CH_PER_GRP-1:0] i_in_vld,
  input  group_data_pld_t               i_in_pld [NUM_GRP*CH_PER_GRP],
  output logic [NUM_GRP-1:0]            o_rdb_vld,
  output group_data_pld_t               o_rdb_pld [NUM_GRP],
  output logic [NUM_GRP-1:0]            o_evdb_vld,
  output group_data_pld_t               o_evdb_pld [NUM_GRP],
  output logic [NUM_GRP-1:0]            o_ovf_err
`ifdef VEC_CACHE_RDB_ARB_CONFLICT_CNT_EN
  , output logic [15:0]                 o_conflict_cnt
`endif
);

  logic [NUM_GRP-1:0] w_rdb_ovf;
  logic [NUM_GRP-1:0] w_evdb_ovf;
`ifdef VEC_CACHE_RDB_ARB_CONFLICT_CNT_EN
  logic [NUM_GRP-1:0] w_rdb_conf;
  logic [NUM_GRP-1:0] w_evdb_conf;
  logic [15:0]        r_conflict_cnt;
`endif

  for (genvar g = 0; g < NUM_GRP; g++) begin : g_grp
    group_data_pld_t w_ch_pld [CH_PER_GRP];

    for (genvar c = 0; c < CH_PER_GRP; c++) begin : g_ch
      assign w_ch_pld[c] = i_in_pld[g*CH_PER_GRP + c];
    end

    if (SPLIT_EVICT != 0) begin : g_split
      logic [CH_PER_GRP-1:0] w_rd_sel;
      logic [CH_PER_GRP-1:0] w_ev_sel;

      // Opcodes other than read/evict match neither class and vanish here.
      for (genvar c = 0; c < CH_PER_GRP; c++) begin : g_cls
        assign w_rd_sel[c] = i_in_vld[g*CH_PER_GRP + c] &&
                             (w_ch_pld[c].cmd_pld.opcode == OPC_READ);
        assign w_ev_sel[c] = i_in_vld[g*CH_PER_GRP + c] &&
                             (w_ch_pld[c].cmd_pld.opcode == OPC_EVICT);
      end

      vec_cache_rdb_grp_arb #(
        .CH_PER_GRP (CH_PER_GRP),
        .SKID_DEPTH (SKID_DEPTH)
      ) u_rdb_arb (
        .clk   (clk),
        .rst   (rst),
        .i_vld (w_rd_sel),
        .i_pld (w_ch_pld),
        .o_vld (o_rdb_vld[g]),
        .o_pld (o_rdb_pld[g]),
        .o_ovf (w_rdb_ovf[g])
`ifdef VEC_CACHE_RDB_ARB_CONFLICT_CNT_EN
        , .o_conflict (w_rdb_conf[g])
`endif
      );

      vec_cache_rdb_grp_arb #(
        .CH_PER_GRP (CH_PER_GRP),
        .SKID_DEPTH (SKID_DEPTH)
      ) u_evdb_arb (
        .clk   (clk),
        .rst   (rst),
        .i_vld (w_ev_sel),
        .i_pld (w_ch_pld),
        .o_vld (o_evdb_vld[g]),
        .o_pld (o_evdb_pld[g]),
        .o_ovf (w_evdb_ovf[g])
`ifdef VEC_CACHE_RDB_ARB_CONFLICT_CNT_EN
        , .o_conflict (w_evdb_conf[g])
`endif
      );
    end else begin : g_unsplit
      vec_cache_rdb_grp_arb #(
        .CH_PER_GRP (CH_PER_GRP),
        .SKID_DEPTH (SKID_DEPTH)
      ) u_rdb_arb (
        .clk   (clk),
        .rst   (rst),
        .i_vld (i_in_vld[g*CH_PER_GRP +: CH_PER_GRP]),
        .i_pld (w_ch_pld),
        .o_vld (o_rdb_vld[g]),
        .o_pld (o_rdb_pld[g]),
        .o_ovf (w_rdb_ovf[g])
`ifdef VEC_CACHE_RDB_ARB_CONFLICT_CNT_EN
        , .o_conflict (w_rdb_conf[g])
`endif
      );

      assign o_evdb_vld[g] = 1'b0;
      assign o_evdb_pld[g] = '0;
      assign w_evdb_ovf[g] = 1'b0;
`ifdef VEC_CACHE_RDB_ARB_CONFLICT_CNT_EN
      assign w_evdb_conf[g] = 1'b0;
`endif
    end
  end

  assign o_ovf_err = w_rdb_ovf | w_evdb_ovf;

`ifdef VEC_CACHE_RDB_ARB_CONFLICT_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      r_conflict_cnt <= '0;
    end else if (((|w_rdb_conf) || (|w_evdb_conf)) && (r_conflict_cnt != 16'hFFFF)) begin
      r_conflict_cnt <= r_conflict_cnt + 16'd1;
    end
  end

  assign o_conflict_cnt = r_conflict_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_vec_cache_rdb_data_arb.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_vec_cache_rdb_data_arb : directed + randomized checks of the arbiter in
// merged (dut0) and split (dut1) configurations against a queue-based model.
// ---------------------------------------------------------------------------
module tb_vec_cache_rdb_data_arb;
  import vector_cache_pkg::*;

  localparam int NG = 4;
  localparam int CH = 2;
  localparam int D  = 2;
  localparam int NC = NG * CH;
  localparam int NM = 3 * NG;

  typedef group_data_pld_t pld_arr_t [NC];

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst;
  logic [NC-1:0]   vld0, vld1;
  pld_arr_t        pld0, pld1;
  logic [NG-1:0]   rv0, ev0, ov0, rv1, ev1, ov1;
  group_data_pld_t rp0 [NG];
  group_data_pld_t ep0 [NG];
  group_data_pld_t rp1 [NG];
  group_data_pld_t ep1 [NG];
`ifdef VEC_CACHE_RDB_ARB_CONFLICT_CNT_EN
  logic [15:0]     cc0, cc1;
`endif

  vec_cache_rdb_data_arb #(.NUM_GRP(NG), .CH_PER_GRP(CH), .SKID_DEPTH(D), .SPLIT_EVICT(0)) dut0 (
    .clk(clk), .rst(rst), .i_in_vld(vld0), .i_in_pld(pld0),
    .o_rdb_vld(rv0), .o_rdb_pld(rp0), .o_evdb_vld(ev0), .o_evdb_pld(ep0), .o_ovf_err(ov0)
`ifdef VEC_CACHE_RDB_ARB_CONFLICT_CNT_EN
    , .o_conflict_cnt(cc0)
`endif
  );

  vec_cache_rdb_data_arb #(.NUM_GRP(NG), .CH_PER_GRP(CH), .SKID_DEPTH(D), .SPLIT_EVICT(1)) dut1 (
    .clk(clk), .rst(rst), .i_in_vld(vld1), .i_in_pld(pld1),
    .o_rdb_vld(rv1), .o_rdb_pld(rp1), .o_evdb_vld(ev1), .o_evdb_pld(ep1), .o_ovf_err(ov1)
`ifdef VEC_CACHE_RDB_ARB_CONFLICT_CNT_EN
    , .o_conflict_cnt(cc1)
`endif
  );

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model. Stream m: 0..3 dut0 RDB, 4..7 dut1 RDB, 8..11 dut1 EVDB.
  group_data_pld_t mq [NM][$];
  int              mrr  [NM];
  bit              movf [NM];
  bit              mvld [NM];
  group_data_pld_t mpld [NM];
  int              mcc  [2];

  function automatic group_data_pld_t rnd_pld();
    logic [23:0] r;
    r = 24'($urandom);
    return r;
  endfunction

  task automatic model_reset();
    for (int m = 0; m < NM; m++) begin
      mq[m].delete();
      mrr[m]  = 0;
      movf[m] = 0;
      mvld[m] = 0;
      mpld[m] = '0;
    end
    mcc[0] = 0;
    mcc[1] = 0;
  endtask

  task automatic model_grp(input int m, input int g, input logic [NC-1:0] v,
                           input pld_arr_t p, output bit conf);
    group_data_pld_t cand[$];
    int winner;
    winner = -1;
    for (int i = 0; i < CH; i++) begin
      int c;
      c = (mrr[m] + i) % CH;
      if (v[g*CH + c]) begin
        cand.push_back(p[g*CH + c]);
        if (winner < 0) winner = c;
      end
    end
    conf = ((mq[m].size() > 0 ? 1 : 0) + cand.size()) > 1;
    if (mq[m].size() > 0) begin
      mvld[m] = 1;
      mpld[m] = mq[m].pop_front();
    end else if (cand.size() > 0) begin
      mvld[m] = 1;
      mpld[m] = cand.pop_front();
      mrr[m]  = (winner + 1) % CH;
    end else begin
      mvld[m] = 0;
    end
    foreach (cand[j]) begin
      if (mq[m].size() < D) mq[m].push_back(cand[j]);
      else movf[m] = 1;
    end
  endtask

  task automatic model_cycle();
    logic [NC-1:0] v1r, v1e;
    bit c, any0, any1;
    if (rst) begin
      model_reset();
      return;
    end
    for (int i = 0; i < NC; i++) begin
      v1r[i] = vld1[i] && (pld1[i].cmd_pld.opcode == 2'd1);
      v1e[i] = vld1[i] && (pld1[i].cmd_pld.opcode == 2'd2);
    end
    any0 = 0;
    any1 = 0;
    for (int g = 0; g < NG; g++) begin
      model_grp(g, g, vld0, pld0, c);          any0 |= c;
      model_grp(NG + g, g, v1r, pld1, c);      any1 |= c;
      model_grp(2*NG + g, g, v1e, pld1, c);    any1 |= c;
    end
    if (any0 && mcc[0] < 65535) mcc[0]++;
    if (any1 && mcc[1] < 65535) mcc[1]++;
  endtask

  // Inputs are set at the falling edge; outputs are read at the next one.
  task automatic clock_cycle();
    model_cycle();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic set_idle();
    vld0 = '0;
    vld1 = '0;
    for (int i = 0; i < NC; i++) begin
      pld0[i] = rnd_pld();
      pld1[i] = rnd_pld();
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    set_idle();
    clock_cycle();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst  = 1'b1;
    vld0 = '1;
    vld1 = '1;
    for (int i = 0; i < NC; i++) begin
      pld0[i] = rnd_pld();
      pld1[i] = rnd_pld();
    end
    clock_cycle();
    clock_cycle();
    n_checks++; if (rv0 !== 4'b0) $display("FAIL reset_rdb_vld0: got %b want 0000", rv0); else n_pass++;
    n_checks++; if (ev0 !== 4'b0) $display("FAIL reset_evdb_vld0: got %b want 0000", ev0); else n_pass++;
    n_checks++; if (ov0 !== 4'b0) $display("FAIL reset_ovf0: got %b want 0000", ov0); else n_pass++;
    n_checks++; if (rv1 !== 4'b0) $display("FAIL reset_rdb_vld1: got %b want 0000", rv1); else n_pass++;
    n_checks++; if (ev1 !== 4'b0) $display("FAIL reset_evdb_vld1: got %b want 0000", ev1); else n_pass++;
    n_checks++; if (ov1 !== 4'b0) $display("FAIL reset_ovf1: got %b want 0000", ov1); else n_pass++;
    for (int g = 0; g < NG; g++) begin
      n_checks++;
      if (rp0[g] !== '0 || rp1[g] !== '0 || ep1[g] !== '0)
        $display("FAIL reset_pld lane %0d: got %h/%h/%h want 0", g, rp0[g], rp1[g], ep1[g]);
      else n_pass++;
    end
`ifdef VEC_CACHE_RDB_ARB_CONFLICT_CNT_EN
    n_checks++; if (cc0 !== 16'd0) $display("FAIL reset_cnt0: got %0d want 0", cc0); else n_pass++;
`endif
    rst = 1'b0;
    set_idle();
    clock_cycle();
    n_checks++; if (rv0 !== 4'b0) $display("FAIL post_reset_idle: got %b want 0000", rv0); else n_pass++;
  endtask

  task automatic test_single_beat();
    group_data_pld_t a;
    a = rnd_pld();
    set_idle();
    vld0    = 8'h04;
    pld0[2] = a;
    clock_cycle();
    n_checks++; if (rv0 !== 4'b0010) $display("FAIL single_vld: got %b want 0010", rv0); else n_pass++;
    n_checks++; if (rp0[1] !== a) $display("FAIL single_pld: got %h want %h", rp0[1], a); else n_pass++;
    set_idle();
    clock_cycle();
    n_checks++; if (rv0 !== 4'b0) $display("FAIL single_idle: got %b want 0000", rv0); else n_pass++;
  endtask

  task automatic test_collision();
    group_data_pld_t a, b;
    a = rnd_pld();
    b = rnd_pld();
    set_idle();
    vld0 = 8'h03;
    pld0[0] = a;
    pld0[1] = b;
    clock_cycle();
    n_checks++; if (rv0 !== 4'b0001 || rp0[0] !== a) $display("FAIL coll_first: got %b/%h want 0001/%h", rv0, rp0[0], a); else n_pass++;
    set_idle();
    clock_cycle();
    n_checks++; if (rv0 !== 4'b0001 || rp0[0] !== b) $display("FAIL coll_second: got %b/%h want 0001/%h", rv0, rp0[0], b); else n_pass++;
    clock_cycle();
    n_checks++; if (rv0 !== 4'b0) $display("FAIL coll_idle: got %b want 0000", rv0); else n_pass++;
    n_checks++; if (ov0 !== 4'b0) $display("FAIL coll_ovf: got %b want 0000", ov0); else n_pass++;
  endtask

  task automatic test_overflow();
    group_data_pld_t a [3];
    group_data_pld_t b [3];
    group_data_pld_t got[$];
    group_data_pld_t want[$];
    do_reset();
    for (int i = 0; i < 3; i++) begin
      a[i] = rnd_pld();
      b[i] = rnd_pld();
    end
    // rr starts at 0: A0 wins, then FIFO order B0, B1, A1, B2; A2 drops.
    want = '{a[0], b[0], b[1], a[1], b[2]};
    for (int t = 0; t < 8; t++) begin
      set_idle();
      if (t < 3) begin
        vld0 = 8'h03;
        pld0[0] = a[t];
        pld0[1] = b[t];
      end
      clock_cycle();
      if (rv0[0]) got.push_back(rp0[0]);
    end
    n_checks++; if (got.size() != 5) $display("FAIL ovf_beat_count: got %0d want 5", got.size()); else n_pass++;
    for (int i = 0; i < 5; i++) begin
      n_checks++;
      if (i >= got.size()) $display("FAIL ovf_order[%0d]: got none want %h", i, want[i]);
      else if (got[i] !== want[i]) $display("FAIL ovf_order[%0d]: got %h want %h", i, got[i], want[i]);
      else n_pass++;
    end
    n_checks++; if (ov0 !== 4'b0001) $display("FAIL ovf_flag: got %b want 0001", ov0); else n_pass++;
    for (int t = 0; t < 4; t++) clock_cycle();
    n_checks++; if (ov0 !== 4'b0001) $display("FAIL ovf_sticky: got %b want 0001", ov0); else n_pass++;
    do_reset();
    n_checks++; if (ov0 !== 4'b0) $display("FAIL ovf_cleared: got %b want 0000", ov0); else n_pass++;
  endtask

  task automatic test_split_evict();
    group_data_pld_t x, y;
    x = rnd_pld();
    y = rnd_pld();
    x.cmd_pld.opcode = 2'd1;
    y.cmd_pld.opcode = 2'd2;
    set_idle();
    vld1 = 8'h03;
    pld1[0] = x;
    pld1[1] = y;
    vld0 = 8'h03;
    pld0[0] = x;
    pld0[1] = y;
    clock_cycle();
    n_checks++; if (rv1 !== 4'b0001 || ev1 !== 4'b0001) $display("FAIL split_vld: got rdb %b evdb %b want 0001/0001", rv1, ev1); else n_pass++;
    n_checks++; if (rp1[0] !== x) $display("FAIL split_rdb_pld: got %h want %h", rp1[0], x); else n_pass++;
    n_checks++; if (ep1[0] !== y) $display("FAIL split_evdb_pld: got %h want %h", ep1[0], y); else n_pass++;
    n_checks++; if (ev0 !== 4'b0) $display("FAIL merged_evdb_tied: got %b want 0000", ev0); else n_pass++;
    set_idle();
    clock_cycle();
    n_checks++; if (rv1 !== 4'b0 || ev1 !== 4'b0) $display("FAIL split_no_fifo: got %b/%b want 0000/0000", rv1, ev1); else n_pass++;
    vld1 = 8'h05;
    pld1[0].cmd_pld.opcode = 2'd0;
    pld1[2].cmd_pld.opcode = 2'd3;
    clock_cycle();
    n_checks++; if (rv1 !== 4'b0 || ev1 !== 4'b0) $display("FAIL split_drop_opc: got %b/%b want 0000/0000", rv1, ev1); else n_pass++;
    set_idle();
    clock_cycle();
  endtask

  task automatic test_reset_mid_drain();
    do_reset();
    set_idle();
    vld0 = 8'h03;
    clock_cycle();
    set_idle();
    vld0 = 8'h03;
    clock_cycle();
    n_checks++; if (rv0[0] !== 1'b1) $display("FAIL drain_prefill: got %b want 1", rv0[0]); else n_pass++;
    rst  = 1'b1;
    vld0 = 8'h03;
    clock_cycle();
    n_checks++; if (rv0 !== 4'b0 || rp0[0] !== '0) $display("FAIL drain_rst_out: got %b/%h want 0000/0", rv0, rp0[0]); else n_pass++;
    rst = 1'b0;
    for (int t = 0; t < 3; t++) begin
      set_idle();
      clock_cycle();
      n_checks++; if (rv0 !== 4'b0) $display("FAIL drain_stale t%0d: got %b want 0000", t, rv0); else n_pass++;
    end
    n_checks++; if (ov0 !== 4'b0) $display("FAIL drain_ovf: got %b want 0000", ov0); else n_pass++;
  endtask

`ifdef VEC_CACHE_RDB_ARB_CONFLICT_CNT_EN
  task automatic test_counter();
    do_reset();
    n_checks++; if (cc0 !== 16'd0) $display("FAIL cnt_start: got %0d want 0", cc0); else n_pass++;
    for (int t = 0; t < 10; t++) begin
      set_idle();
      vld0 = 8'h03;
      clock_cycle();
      set_idle();
      clock_cycle();
    end
    n_checks++; if (cc0 !== 16'd10) $display("FAIL cnt_ten: got %0d want 10", cc0); else n_pass++;
    n_checks++; if (cc1 !== 16'd0) $display("FAIL cnt_idle_dut: got %0d want 0", cc1); else n_pass++;
  endtask
`endif

  task automatic test_random();
    logic [NG-1:0] e_rv0, e_ov0, e_rv1, e_ev1, e_ov1;
    do_reset();
    for (int t = 0; t < 400; t++) begin
      rst  = ($urandom_range(0, 63) == 0);
      vld0 = NC'($urandom & $urandom);
      vld1 = NC'($urandom & $urandom);
      for (int i = 0; i < NC; i++) begin
        pld0[i] = rnd_pld();
        pld1[i] = rnd_pld();
      end
      clock_cycle();
      for (int g = 0; g < NG; g++) begin
        e_rv0[g] = mvld[g];
        e_ov0[g] = movf[g];
        e_rv1[g] = mvld[NG + g];
        e_ev1[g] = mvld[2*NG + g];
        e_ov1[g] = movf[NG + g] | movf[2*NG + g];
      end
      n_checks++; if (rv0 !== e_rv0) $display("FAIL rnd_rdb_vld0 t%0d: got %b want %b", t, rv0, e_rv0); else n_pass++;
      n_checks++; if (ov0 !== e_ov0) $display("FAIL rnd_ovf0 t%0d: got %b want %b", t, ov0, e_ov0); else n_pass++;
      n_checks++; if (rv1 !== e_rv1) $display("FAIL rnd_rdb_vld1 t%0d: got %b want %b", t, rv1, e_rv1); else n_pass++;
      n_checks++; if (ev1 !== e_ev1) $display("FAIL rnd_evdb_vld1 t%0d: got %b want %b", t, ev1, e_ev1); else n_pass++;
      n_checks++; if (ov1 !== e_ov1) $display("FAIL rnd_ovf1 t%0d: got %b want %b", t, ov1, e_ov1); else n_pass++;
      for (int g = 0; g < NG; g++) begin
        if (e_rv0[g]) begin
          n_checks++; if (rp0[g] !== mpld[g]) $display("FAIL rnd_rdb_pld0[%0d] t%0d: got %h want %h", g, t, rp0[g], mpld[g]); else n_pass++;
        end
        if (e_rv1[g]) begin
          n_checks++; if (rp1[g] !== mpld[NG + g]) $display("FAIL rnd_rdb_pld1[%0d] t%0d: got %h want %h", g, t, rp1[g], mpld[NG + g]); else n_pass++;
        end
        if (e_ev1[g]) begin
          n_checks++; if (ep1[g] !== mpld[2*NG + g]) $display("FAIL rnd_evdb_pld1[%0d] t%0d: got %h want %h", g, t, ep1[g], mpld[2*NG + g]); else n_pass++;
        end
      end
`ifdef VEC_CACHE_RDB_ARB_CONFLICT_CNT_EN
      n_checks++; if (cc0 !== 16'(mcc[0])) $display("FAIL rnd_cnt0 t%0d: got %0d want %0d", t, cc0, mcc[0]); else n_pass++;
      n_checks++; if (cc1 !== 16'(mcc[1])) $display("FAIL rnd_cnt1 t%0d: got %0d want %0d", t, cc1, mcc[1]); else n_pass++;
`endif
    end
    rst = 1'b0;
    set_idle();
    clock_cycle();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    set_idle();
    model_reset();
    @(negedge clk);
    test_reset();
    test_single_beat();
    test_collision();
    test_overflow();
    test_split_evict();
    test_reset_mid_drain();
`ifdef VEC_CACHE_RDB_ARB_CONFLICT_CNT_EN
    test_counter();
`endif
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
